rr_select_arbiter8: RTL and testbench

//  Upstream control stage for the 32-bit 8:1 word multiplexer (eightto1mux).

---
 rtl/rr_select_pkg.sv | 19 +
 rtl/rr_pick8.sv | 45 ++++
 rtl/rr_select_arbiter8.sv | 89 ++++++++
 tb/tb_rr_select_arbiter8.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_select_pkg.sv
// Shared constants and helpers for the rr_select_arbiter8 control stage.
package rr_select_pkg;

   localparam int N_CH  = 8;
   localparam int SEL_W = $clog2(N_CH);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   // Pointer reset value: last channel, so the scan after reset starts at ch0.
   localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(N_CH - 1);

   function automatic logic [N_CH-1:0] chan_onehot(input logic [SEL_W-1:0] ch);
      chan_onehot     = '0;
      chan_onehot[ch] = 1'b1;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational 8-way pick: rotate by ptr+1, priority-encode, un-rotate.
// ARB_FIXED_PRIO_EN selects a plain lowest-index priority encoder instead.
module rr_pick8
   import rr_select_pkg::*;
(
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] pick
);

   assign any = |req;

`ifdef ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      pick = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (req[i]) pick = SEL_W'(i);
      end
   end
`else
   logic [SEL_W-1:0]  start;
   logic [2*N_CH-1:0] dbl;
   logic [N_CH-1:0]   rot;
   logic [SEL_W-1:0]  idx;

   // start wraps naturally in SEL_W bits (ptr=7 -> start=0).
   assign start = ptr + SEL_W'(1);
   assign dbl   = {req, req};
   assign rot   = dbl[start +: N_CH];

   always_comb begin
      idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (rot[i]) idx = SEL_W'(i);
      end
   end

   assign pick = start + idx;
`endif

endmodule

// File: rtl/rr_select_arbiter8.sv
// Round-robin select arbiter driving an external 8:1 word mux and capturing its word.
// Optional macro ARB_FIXED_PRIO_EN: fixed lowest-index priority, pointer held at reset.
module rr_select_arbiter8
   import rr_select_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   req,
   output logic [N_CH-1:0]   gnt,
   output logic [SEL_W-1:0]  sel,
   input  logic [DATA_W-1:0] mux_out,
   output logic [DATA_W-1:0] out_data,
   output logic [SEL_W-1:0]  out_chan,
   output logic              out_valid,
   input  logic              out_ready
);

   logic [1:0]       state;
   logic [SEL_W-1:0] ptr;
   logic [N_CH-1:0]  scan_req;
   logic             any;
   logic [SEL_W-1:0] pick;

`ifdef ARB_FIXED_PRIO_EN
   assign scan_req = req;
`else
   // In HOLD the granted channel may still show its request; skip it on re-scan.
   assign scan_req = (state == ST_HOLD) ? (req & ~chan_onehot(out_chan)) : req;
`endif

   rr_pick8 u_pick (
      .req  (scan_req),
      .ptr  (ptr),
      .any  (any),
      .pick (pick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= PTR_RST;
         sel       <= '0;
         gnt       <= '0;
         out_data  <= '0;
         out_chan  <= '0;
         out_valid <= 1'b0;
      end else begin
         gnt <= '0;
         case (state)
            ST_IDLE: begin
               if (any) begin
                  sel   <= pick;
                  state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               // Capture only if the selected requester is still asking.
               if (req[sel]) begin
                  out_data  <= mux_out;
                  out_chan  <= sel;
                  out_valid <= 1'b1;
                  gnt       <= chan_onehot(sel);
`ifndef ARB_FIXED_PRIO_EN
                  ptr       <= sel;
`endif
                  state     <= ST_HOLD;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (any) begin
                     sel   <= pick;
                     state <= ST_SETTLE;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_select_arbiter8.sv
// Scoreboard bench for rr_select_arbiter8; mux inputs a..h tied to 0..7.
module tb_rr_select_arbiter8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [7:0]  req = '0;
   logic [7:0]  gnt;
   logic [2:0]  sel;
   logic [31:0] mux_out;
   logic [31:0] out_data;
   logic [2:0]  out_chan;
   logic        out_valid;
   logic        out_ready = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int exp_q[$];

   rr_select_arbiter8 #(.DATA_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .sel       (sel),
      .mux_out   (mux_out),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // eightto1mux model with inputs a..h = 0..7
   always_comb begin
      case (sel)
         3'd0: mux_out = 32'd0;
         3'd1: mux_out = 32'd1;
         3'd2: mux_out = 32'd2;
         3'd3: mux_out = 32'd3;
         3'd4: mux_out = 32'd4;
         3'd5: mux_out = 32'd5;
         3'd6: mux_out = 32'd6;
         default: mux_out = 32'd7;
      endcase
   end

   always #5 clk = ~clk;

   task automatic apply_reset();
      req       = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_gnt(input int budget, output int cycles, output bit seen);
      cycles = 0;
      seen   = 1'b0;
      while (cycles < budget && !seen) begin
         @(negedge clk);
         cycles++;
         if (gnt != 8'h00) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      req = '0;
      out_ready = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      vectors++; if (sel !== 3'd0) begin miscompares++; $display("FAIL reset_sel: got %0d want 0", sel); end
      vectors++; if (gnt !== 8'h00) begin miscompares++; $display("FAIL reset_gnt: got %h want 00", gnt); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      vectors++; if (out_data !== 32'd0) begin miscompares++; $display("FAIL reset_data: got %0d want 0", out_data); end
      vectors++; if (out_chan !== 3'd0) begin miscompares++; $display("FAIL reset_chan: got %0d want 0", out_chan); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++; if (out_valid !== 1'b0 || sel !== 3'd0) begin miscompares++; $display("FAIL idle_no_req: valid %b sel %0d want 0 0", out_valid, sel); end
   endtask

   task automatic test_latency();
      int exp;
      apply_reset();
      req = 8'h08;
      out_ready = 1'b1;
      exp_q.push_back(3);
      @(negedge clk);
      vectors++; if (sel !== 3'd3) begin miscompares++; $display("FAIL lat_sel: got %0d want 3", sel); end
      vectors++; if (out_valid !== 1'b0 || gnt !== 8'h00) begin miscompares++; $display("FAIL lat_early: valid %b gnt %h want 0 00", out_valid, gnt); end
      @(negedge clk);
      exp = exp_q.pop_front();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL lat_valid: got %b want 1", out_valid); end
      vectors++; if (gnt !== 8'h08) begin miscompares++; $display("FAIL lat_gnt: got %h want 08", gnt); end
      vectors++; if (out_data !== 32'(exp)) begin miscompares++; $display("FAIL lat_data: got %0d want %0d", out_data, exp); end
      vectors++; if (out_chan !== 3'(exp)) begin miscompares++; $display("FAIL lat_chan: got %0d want %0d", out_chan, exp); end
      req = 8'h00;
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0 || gnt !== 8'h00) begin miscompares++; $display("FAIL lat_accept: valid %b gnt %h want 0 00", out_valid, gnt); end
   endtask

   task automatic test_round_robin();
      int cyc;
      bit seen;
      int exp;
      apply_reset();
      req = 8'hFF;
      out_ready = 1'b1;
      for (int k = 0; k < 9; k++) exp_q.push_back(k % 8);
      for (int k = 0; k < 9; k++) begin
         wait_gnt(6, cyc, seen);
         vectors++; if (!seen || cyc != 2) begin miscompares++; $display("FAIL rr_interval[%0d]: got %0d cycles (seen %b) want 2", k, cyc, seen); end
         if (seen) begin
            exp = exp_q.pop_front();
            vectors++; if (out_chan !== 3'(exp)) begin miscompares++; $display("FAIL rr_chan[%0d]: got %0d want %0d", k, out_chan, exp); end
            vectors++; if (out_data !== 32'(exp)) begin miscompares++; $display("FAIL rr_data[%0d]: got %0d want %0d", k, out_data, exp); end
            vectors++; if (gnt !== 8'(1 << exp)) begin miscompares++; $display("FAIL rr_gnt[%0d]: got %h want %h", k, gnt, 8'(1 << exp)); end
         end
      end
      req = 8'h00;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_fixed_prio();
      int cyc;
      bit seen;
      int exp;
      apply_reset();
      req = 8'hFF;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) exp_q.push_back(0);
      for (int k = 0; k < 6; k++) begin
         wait_gnt(6, cyc, seen);
         vectors++; if (!seen) begin miscompares++; $display("FAIL fp_timeout[%0d]: got no gnt want gnt", k); end
         if (seen) begin
            exp = exp_q.pop_front();
            vectors++; if (out_chan !== 3'(exp)) begin miscompares++; $display("FAIL fp_chan[%0d]: got %0d want %0d", k, out_chan, exp); end
         end
      end
      req = 8'h00;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_backpressure();
      int cyc;
      bit seen;
      int exp;
      apply_reset();
      req = 8'h21;
      out_ready = 1'b0;
      exp_q.push_back(0);
      exp_q.push_back(5);
      wait_gnt(6, cyc, seen);
      exp = exp_q.pop_front();
      vectors++; if (!seen || out_chan !== 3'(exp) || gnt !== 8'h01) begin miscompares++; $display("FAIL bp_first: seen %b chan %0d gnt %h want 1 %0d 01", seen, out_chan, gnt, exp); end
      req = 8'h20;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         vectors++; if (out_data !== 32'd0 || sel !== 3'd0 || out_valid !== 1'b1 || gnt !== 8'h00) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: data %0d sel %0d valid %b gnt %h want 0 0 1 00", k, out_data, sel, out_valid, gnt);
         end
      end
      out_ready = 1'b1;
      wait_gnt(6, cyc, seen);
      exp = exp_q.pop_front();
      vectors++; if (!seen || cyc != 2) begin miscompares++; $display("FAIL bp_resume: got %0d cycles (seen %b) want 2", cyc, seen); end
      vectors++; if (out_chan !== 3'(exp) || out_data !== 32'(exp)) begin miscompares++; $display("FAIL bp_second: chan %0d data %0d want %0d", out_chan, out_data, exp); end
      req = 8'h00;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_drop_in_settle();
      int cyc;
      bit seen;
      int exp;
      apply_reset();
      req = 8'h04;
      out_ready = 1'b1;
      @(negedge clk);
      vectors++; if (sel !== 3'd2) begin miscompares++; $display("FAIL drop_sel: got %0d want 2", sel); end
      req = 8'h00;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         vectors++; if (gnt !== 8'h00 || out_valid !== 1'b0) begin miscompares++; $display("FAIL drop_nogrant[%0d]: gnt %h valid %b want 00 0", k, gnt, out_valid); end
      end
      req = 8'h04;
      exp_q.push_back(2);
      wait_gnt(6, cyc, seen);
      exp = exp_q.pop_front();
      vectors++; if (!seen || cyc != 2) begin miscompares++; $display("FAIL drop_retry_lat: got %0d cycles (seen %b) want 2", cyc, seen); end
      vectors++; if (out_chan !== 3'(exp) || gnt !== 8'h04) begin miscompares++; $display("FAIL drop_retry: chan %0d gnt %h want %0d 04", out_chan, gnt, exp); end
      req = 8'h00;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_in_hold();
      int cyc;
      bit seen;
      int exp;
      apply_reset();
      req = 8'h81;
      out_ready = 1'b0;
      exp_q.push_back(0);
      wait_gnt(6, cyc, seen);
      exp = exp_q.pop_front();
      vectors++; if (!seen || out_chan !== 3'(exp) || out_valid !== 1'b1) begin miscompares++; $display("FAIL rst_hold_pre: seen %b chan %0d valid %b want 1 %0d 1", seen, out_chan, out_valid, exp); end
      rst_n = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0 || gnt !== 8'h00) begin miscompares++; $display("FAIL rst_hold_abort: valid %b gnt %h want 0 00", out_valid, gnt); end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      exp_q.push_back(0);
      exp_q.push_back(7);
      for (int k = 0; k < 2; k++) begin
         wait_gnt(6, cyc, seen);
         vectors++; if (!seen) begin miscompares++; $display("FAIL rst_hold_timeout[%0d]: got no gnt want gnt", k); end
         if (seen) begin
            exp = exp_q.pop_front();
            vectors++; if (out_chan !== 3'(exp) || out_data !== 32'(exp)) begin miscompares++; $display("FAIL rst_hold_chan[%0d]: chan %0d data %0d want %0d", k, out_chan, out_data, exp); end
         end
      end
      req = 8'h00;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_latency();
`ifdef ARB_FIXED_PRIO_EN
      test_fixed_prio();
`else
      test_round_robin();
      test_backpressure();
      test_drop_in_settle();
      test_reset_in_hold();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
